// File: rtl/dmem_arb_pkg.sv
// Shared constants for the data-memory bus arbiter: FSM encodings and the beat address stride.
package dmem_arb_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BURST = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam int ADDR_STEP = 4;

endpackage

// File: rtl/dmem_arb_beat_ctr.sv
// Burst address/beat bookkeeping: word-aligned address that wraps, remaining-beat counter and last flag.
module dmem_arb_beat_ctr
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int LEN_W  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [LEN_W-1:0]  load_len,
   input  logic              step,
   output logic [ADDR_W-1:0] cur_addr,
   output logic              last
);

   logic [LEN_W-1:0] remaining;

   always_ff @(posedge clk) begin
      if (!reset) begin
         cur_addr  <= '0;
         remaining <= '0;
      end else if (load) begin
         cur_addr  <= {load_addr[ADDR_W-1:2], 2'b00};
         remaining <= load_len;
      end else if (step) begin
         cur_addr <= cur_addr + ADDR_W'(ADDR_STEP);
         if (remaining != '0)
            remaining <= remaining - 1'b1;
      end
   end

   assign last = (remaining == '0);

endmodule

// File: rtl/dmem_bus_arbiter.sv
// Data-memory arbiter: CPU always wins, DMA bursts fill CPU-idle cycles.
// Optional starvation flag built only when ARB_STARVE_IRQ_EN is defined.
module dmem_bus_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int LEN_W        = 4,
   parameter int STARVE_LIMIT = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_read,
   input  logic              cpu_write,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dma_req,
   input  logic              dma_write,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [LEN_W-1:0]  dma_len,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_beat,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              dma_rvalid,
   output logic              dma_busy,
   output logic              dma_done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_read,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              starve_irq
);

   if (STARVE_LIMIT < 1) begin : g_bad_limit
      $error("STARVE_LIMIT must be at least 1");
   end

   logic [1:0]        state;
   logic              dma_write_q;
   logic              cpu_act;
   logic              load;
   logic              last;
   logic [ADDR_W-1:0] cur_addr;

   assign cpu_act  = cpu_read | cpu_write;
   assign load     = (state == ST_IDLE) && dma_req;
   // No beat may reach memory in a cycle that reset is about to abort.
   assign dma_beat = (state == ST_BURST) && !cpu_act && reset;
   assign dma_busy = (state != ST_IDLE);
   assign dma_done = (state == ST_DONE);
   assign cpu_rdata = mem_rdata;

   dmem_arb_beat_ctr #(
      .ADDR_W (ADDR_W),
      .LEN_W  (LEN_W)
   ) u_beat_ctr (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .load_addr (dma_addr),
      .load_len  (dma_len),
      .step      (dma_beat),
      .cur_addr  (cur_addr),
      .last      (last)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= ST_IDLE;
         dma_write_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (dma_req) begin
                  state       <= ST_BURST;
                  dma_write_q <= dma_write;
               end
            end
            ST_BURST: begin
               if (dma_beat && last)
                  state <= ST_DONE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         dma_rdata  <= '0;
         dma_rvalid <= 1'b0;
      end else begin
         dma_rvalid <= dma_beat && !dma_write_q;
         if (dma_beat && !dma_write_q)
            dma_rdata <= mem_rdata;
      end
   end

   always_comb begin
      mem_addr  = cpu_addr;
      mem_read  = cpu_read;
      mem_write = cpu_write;
      mem_wdata = cpu_wdata;
      if (dma_beat) begin
         mem_addr  = cur_addr;
         mem_read  = !dma_write_q;
         mem_write = dma_write_q;
         mem_wdata = dma_wdata;
      end
   end

`ifdef ARB_STARVE_IRQ_EN
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

   logic [CNT_W-1:0] starve_cnt;

   // In BURST without a beat the CPU is necessarily holding the bus.
   always_ff @(posedge clk) begin
      if (!reset) begin
         starve_cnt <= '0;
         starve_irq <= 1'b0;
      end else if (state != ST_BURST || dma_beat) begin
         starve_cnt <= '0;
         if (dma_beat)
            starve_irq <= 1'b0;
      end else begin
         if (starve_cnt != CNT_W'(STARVE_LIMIT))
            starve_cnt <= starve_cnt + 1'b1;
         if (starve_cnt >= CNT_W'(STARVE_LIMIT - 1))
            starve_irq <= 1'b1;
      end
   end
`else
   assign starve_irq = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Scoreboard bench for dmem_bus_arbiter: expected beats queued at burst start, checked as they appear.
module tb_dmem_bus_arbiter;

   typedef struct {
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
      logic        last;
   } beat_t;

   localparam logic [31:0] WBASE = 32'hC0DE_0000;

   logic        clk;
   logic        reset;
   logic [31:0] cpu_addr;
   logic        cpu_read;
   logic        cpu_write;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        dma_req;
   logic        dma_write;
   logic [31:0] dma_addr;
   logic [3:0]  dma_len;
   logic [31:0] dma_wdata;
   logic        dma_beat;
   logic [31:0] dma_rdata;
   logic        dma_rvalid;
   logic        dma_busy;
   logic        dma_done;
   logic [31:0] mem_addr;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        starve_irq;

   int          checks = 0;
   int          passed = 0;
   beat_t       beat_q[$];
   logic        rv_pend = 1'b0;
   logic [31:0] rv_data = '0;
   logic        done_pend = 1'b0;
   logic [31:0] wr_idx = '0;
   logic        exp_irq;

   dmem_bus_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .cpu_addr   (cpu_addr),
      .cpu_read   (cpu_read),
      .cpu_write  (cpu_write),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .dma_req    (dma_req),
      .dma_write  (dma_write),
      .dma_addr   (dma_addr),
      .dma_len    (dma_len),
      .dma_wdata  (dma_wdata),
      .dma_beat   (dma_beat),
      .dma_rdata  (dma_rdata),
      .dma_rvalid (dma_rvalid),
      .dma_busy   (dma_busy),
      .dma_done   (dma_done),
      .mem_addr   (mem_addr),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .starve_irq (starve_irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bench memory: one fixed word, everything else derived from the address.
   function automatic logic [31:0] memModel(input logic [31:0] a);
      return (a == 32'h100) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0F0F);
   endfunction

   assign mem_rdata = memModel(mem_addr);
   assign dma_wdata = WBASE + wr_idx;

   always @(posedge clk) if (dma_beat) wr_idx <= wr_idx + 1;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   // Called at posedge+1; leaves at posedge+1 of the first BURST cycle.
   task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] len, input logic wr);
      logic [31:0] base;
      beat_t b;
      base = {addr[31:2], 2'b00};
      for (int i = 0; i <= int'(len); i++) begin
         b.addr  = base + 32'(4 * i);
         b.write = wr;
         b.wdata = WBASE + wr_idx + 32'(i);
         b.last  = (i == int'(len));
         beat_q.push_back(b);
      end
      dma_req   = 1'b1;
      dma_addr  = addr;
      dma_len   = len;
      dma_write = wr;
      @(posedge clk); #1;
      dma_req   = 1'b0;
      dma_addr  = $urandom;
      dma_len   = 4'($urandom);
      dma_write = 1'($urandom);
   endtask

   task automatic waitIdle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         if (!dma_busy && beat_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) checkOutput("idle_timeout", 1, 0);
   endtask

   always @(negedge clk) begin
      beat_t e;
      if (reset) begin
         if (dma_rvalid || rv_pend) begin
            checkOutput("rvalid", dma_rvalid, rv_pend);
            if (rv_pend) checkOutput("rdata", dma_rdata, rv_data);
         end
         if (dma_done || done_pend) checkOutput("done", dma_done, done_pend);
         rv_pend   = 1'b0;
         done_pend = 1'b0;
         if (cpu_read || cpu_write) begin
            checkOutput("cpu_no_beat", dma_beat, 0);
            checkOutput("cpu_mem_addr", mem_addr, cpu_addr);
         end
         if (dma_beat) begin
            if (beat_q.size() == 0) begin
               checkOutput("unexpected_beat", 1, 0);
            end else begin
               e = beat_q.pop_front();
               checkOutput("beat_addr", mem_addr, e.addr);
               checkOutput("beat_wr", mem_write, e.write);
               checkOutput("beat_rd", mem_read, !e.write);
               if (e.write) checkOutput("beat_wdata", mem_wdata, e.wdata);
               else begin
                  rv_pend = 1'b1;
                  rv_data = memModel(e.addr);
               end
               done_pend = e.last;
            end
         end
      end
   end

`ifdef ARB_STARVE_IRQ_EN
   initial exp_irq = 1'b1;
`else
   initial exp_irq = 1'b0;
`endif

   initial begin
      reset = 1'b0;
      cpu_addr = '0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_wdata = '0;
      dma_req = 1'b0; dma_write = 1'b0; dma_addr = '0; dma_len = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_busy", dma_busy, 0);
      checkOutput("rst_done", dma_done, 0);
      checkOutput("rst_rvalid", dma_rvalid, 0);
      checkOutput("rst_rdata", dma_rdata, 0);
      checkOutput("rst_irq", starve_irq, 0);
      reset = 1'b1;
      @(posedge clk); #1;

      // CPU-only read passes straight through.
      cpu_read = 1'b1; cpu_addr = 32'h100;
      #1;
      checkOutput("t1_addr", mem_addr, 32'h100);
      checkOutput("t1_rdata", cpu_rdata, 32'hDEAD_BEEF);
      checkOutput("t1_beat", dma_beat, 0);
      checkOutput("t1_rd", mem_read, 1);
      @(posedge clk); #1;
      cpu_read = 1'b0; cpu_write = 1'b1; cpu_addr = 32'h44; cpu_wdata = 32'h1234_5678;
      #1;
      checkOutput("t1_wdata", mem_wdata, 32'h1234_5678);
      checkOutput("t1_wr", mem_write, 1);
      @(posedge clk); #1;
      cpu_write = 1'b0;

      // Idle-bus write burst: four back-to-back beats, done right after.
      applyStimulus(32'h203, 4'd3, 1'b1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("t2_beat", dma_beat, 1);
      end
      @(negedge clk);
      checkOutput("t2_done", dma_done, 1);
      checkOutput("t2_busy_done", dma_busy, 1);
      @(posedge clk); #1;
      checkOutput("t2_busy_after", dma_busy, 0);

      // Read burst with CPU holding the bus for three cycles (request overlaps a CPU access).
      cpu_read = 1'b1; cpu_addr = 32'h80;
      applyStimulus(32'h400, 4'd1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("t3_deferred", dma_beat, 0);
         checkOutput("t3_busy", dma_busy, 1);
         @(posedge clk); #1;
      end
      cpu_read = 1'b0;
      @(negedge clk);
      checkOutput("t3_first_beat", dma_beat, 1);
      waitIdle();

      // Address wrap at the top of memory.
      applyStimulus(32'hFFFF_FFFC, 4'd1, 1'b0);
      waitIdle();

      // Reset after one of four beats aborts silently.
      applyStimulus(32'h300, 4'd3, 1'b1);
      @(negedge clk);
      checkOutput("t5_first_beat", dma_beat, 1);
      @(posedge clk); #1;
      reset = 1'b0;
      beat_q.delete();
      rv_pend = 1'b0;
      done_pend = 1'b0;
      @(negedge clk);
      checkOutput("t5_beat_in_rst", dma_beat, 0);
      checkOutput("t5_memwr_in_rst", mem_write, 0);
      @(posedge clk); #1;
      checkOutput("t5_busy", dma_busy, 0);
      checkOutput("t5_done", dma_done, 0);
      checkOutput("t5_rvalid", dma_rvalid, 0);
      checkOutput("t5_rdata", dma_rdata, 0);
      checkOutput("t5_irq", starve_irq, 0);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("t5_no_done", dma_done, 0);
         checkOutput("t5_no_beat", dma_beat, 0);
      end
      @(posedge clk); #1;
      applyStimulus(32'h500, 4'd0, 1'b0);
      waitIdle();

      // Long CPU blockage during a burst: starvation flag (stays 0 when not built).
      cpu_read = 1'b1; cpu_addr = 32'h600;
      applyStimulus(32'h700, 4'd0, 1'b0);
      for (int i = 1; i <= 18; i++) begin
         @(negedge clk);
         checkOutput("t6_irq_blocked", starve_irq, (i > 16) ? exp_irq : 1'b0);
         @(posedge clk); #1;
      end
      cpu_read = 1'b0;
      @(negedge clk);
      checkOutput("t6_beat", dma_beat, 1);
      checkOutput("t6_irq_beat", starve_irq, exp_irq);
      @(negedge clk);
      checkOutput("t6_irq_cleared", starve_irq, 0);
      @(posedge clk); #1;
      waitIdle();

      checkOutput("beat_q_empty", beat_q.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
